load_store_unit: RTL and testbench

- Initiator-side sequencer for the single-ported data_memory: drives mem_addr, mem_write_data, mem_write and mem_read, and samples mem_read_data.
- Accepts byte, halfword and word load/store requests from the CPU datapath over a valid/ready handshake.
- Performs sub-word stores as read-modify-write, and sign- or zero-extends loads.
- Returns one response per request; misaligned and out-of-range accesses are flagged and never touch memory.

---
 rtl/lsu_pkg.sv | 12 +
 rtl/lsu_byte_lane.sv | 41 ++++
 rtl/load_store_unit.sv | 149 ++++++++++++++
 tb/tb_load_store_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Pure declarations: no logic, no latency, no flow control.
// Imported by load_store_unit and lsu_byte_lane.
package lsu_pkg;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} lsu_size_e;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} lsu_state_e;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/lsu_byte_lane.sv
// Lane steering for the load/store unit: sub-word store merge and load extract/extend.
// Purely combinational, zero latency.
// No flow control; outputs follow inputs.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0]                   word_q,
  input  logic [31:0]                   wdata,
  input  logic [1:0]                    size,
  input  logic [$clog2(WORD_BYTES)-1:0] offset,
  input  logic                          is_signed,
  output logic [31:0]                   merged,
  output logic [31:0]                   rdata
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store merge: keep the fetched word and overwrite only the addressed lane.
  always_comb begin
    merged = wdata;
    if (size == SZ_BYTE) begin
      merged = word_q;
      merged[{offset, 3'b000} +: 8] = wdata[7:0];
    end else if (size == SZ_HALF) begin
      merged = word_q;
      merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
    end
  end

  always_comb begin
    ld_byte = word_q[{offset, 3'b000} +: 8];
    ld_half = word_q[{offset[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: rdata = {{24{is_signed & ld_byte[7]}}, ld_byte};
      SZ_HALF: rdata = {{16{is_signed & ld_half[15]}}, ld_half};
      default: rdata = word_q;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer for single-ported data_memory; sub-word stores are read-modify-write. Optional LSU_STATS_EN adds load/store counters.
// Latency handshake->resp_valid: load 2, word store 2, sub-word store 3, error 1.
// One request in flight; req_ready low until the response is taken by resp_ready.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_AW = 8,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [31:0]       mem_read_data
`ifdef LSU_STATS_EN
  ,
  output logic [15:0]       load_count,
  output logic [15:0]       store_count
`endif
);

  lsu_state_e        state, state_nxt;
  logic              write_q, signed_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, word_q;
  logic              req_hs, req_err, misaligned, out_of_range, bad_size;
  logic [31:0]       lane_merged, lane_rdata, word_addr;

  assign req_hs       = req_valid && req_ready;
  assign out_of_range = (req_addr >> MEM_AW) != '0;
  assign req_err      = misaligned | out_of_range | bad_size;
  assign word_addr    = 32'({addr_q[ADDR_W-1:2], 2'b00});

  always_comb begin
    misaligned = 1'b0;
    bad_size   = 1'b0;
    case (req_size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = req_addr[0];
      SZ_WORD: misaligned = (req_addr[1:0] != 2'b00);
      default: bad_size = 1'b1;
    endcase
  end

  lsu_byte_lane u_lane (
    .word_q    (word_q),
    .wdata     (wdata_q),
    .size      (size_q),
    .offset    (addr_q[1:0]),
    .is_signed (signed_q),
    .merged    (lane_merged),
    .rdata     (lane_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
    end else begin
      state <= state_nxt;
      if (req_hs) begin
        write_q  <= req_write;
        signed_q <= req_signed;
        err_q    <= req_err;
        size_q   <= req_size;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      if (state == RD) word_q <= mem_read_data;
    end
  end

  always_comb begin
    state_nxt      = state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_rdata     = '0;
    resp_err       = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    mem_write      = 1'b0;
    mem_read       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                                state_nxt = RESP;
          else if (!req_write || req_size != SZ_WORD) state_nxt = RD;
          else                                        state_nxt = WR;
        end
      end
      RD: begin
        mem_read  = 1'b1;
        mem_addr  = word_addr;
        state_nxt = write_q ? WR : RESP;
      end
      WR: begin
        mem_write      = 1'b1;
        mem_addr       = word_addr;
        mem_write_data = lane_merged;
        state_nxt      = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        // Stores and faulted accesses return zero data.
        resp_rdata = (err_q || write_q) ? 32'h0 : lane_rdata;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef LSU_STATS_EN
  logic resp_done;
  assign resp_done = (state == RESP) && resp_ready && !err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_count  <= '0;
      store_count <= '0;
    end else if (resp_done) begin
      if (write_q && store_count != 16'hFFFF)  store_count <= store_count + 16'd1;
      if (!write_q && load_count != 16'hFFFF)  load_count  <= load_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-array memory model and per-cycle scoreboard.
module tb_load_store_unit;

  logic        clk, rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_write, mem_read;

  load_store_unit #(.MEM_AW(8), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // data_memory stand-in: combinational read, write on clock edge.
  logic [31:0] dmem [0:63];
  bit          dmem_init = 1'b0;
  assign mem_read_data = dmem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (!dmem_init) begin
      for (int i = 0; i < 64; i++) dmem[i] <= 32'h0;
      dmem_init <= 1'b1;
    end else if (mem_write) begin
      dmem[mem_addr[7:2]] <= mem_write_data;
    end
  end

  int nerr = 0;
  int nchk = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    int          lat;
    int          rd;
    int          wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    int          hs;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  ref_mem [0:255];
  int          rd_cnt = 0, wr_cnt = 0;
  bit          front_seen = 1'b0;
  logic [31:0] last_wdata = 32'h0;

  // Scoreboard: every cycle, compare DUT against the expectation at the head of the queue.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      rd_cnt = 0;
      wr_cnt = 0;
      front_seen = 1'b0;
    end else begin
      chk("rd_wr_excl", 32'(mem_read & mem_write), 32'h0);
      if (req_ready) chk("idle_mem_addr", mem_addr, 32'h0);
      if (mem_read) begin
        rd_cnt++;
        if (exp_q.size() > 0) chk("rd_addr", mem_addr, exp_q[0].waddr);
      end
      if (mem_write) begin
        wr_cnt++;
        last_wdata = mem_write_data;
        if (exp_q.size() > 0) begin
          chk("wr_addr", mem_addr, exp_q[0].waddr);
          chk("wr_data", mem_write_data, exp_q[0].wdata);
        end
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_resp", 32'(resp_valid), 32'h0);
        end else begin
          if (!front_seen) begin
            chk("latency", 32'(cyc - exp_q[0].hs + 1), 32'(exp_q[0].lat));
            chk("mem_reads", 32'(rd_cnt), 32'(exp_q[0].rd));
            chk("mem_writes", 32'(wr_cnt), 32'(exp_q[0].wr));
            front_seen = 1'b1;
          end
          chk("resp_rdata", resp_rdata, exp_q[0].rdata);
          chk("resp_err", 32'(resp_err), 32'(exp_q[0].err));
          chk("busy_req_ready", 32'(req_ready), 32'h0);
          if (resp_ready) begin
            void'(exp_q.pop_front());
            front_seen = 1'b0;
            rd_cnt = 0;
            wr_cnt = 0;
          end
        end
      end
    end
  end

  // Computes the expected outcome from the byte-level memory model, then drives the handshake.
  task automatic issue(input bit wr, input logic [1:0] sz, input bit sg,
                       input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    int   nb, base, n;
    logic [31:0] v;
    nb = 1 << sz;
    e.err = (sz == 2'd3) || (sz == 2'd1 && addr[0]) ||
            (sz == 2'd2 && addr[1:0] != 2'b00) || (addr >= 32'h100);
    e.waddr = addr & 32'hFFFF_FFFC;
    e.wdata = 32'h0;
    e.rdata = 32'h0;
    if (e.err) begin
      e.lat = 1; e.rd = 0; e.wr = 0;
    end else if (!wr) begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[int'(addr[7:0]) + i]) << (8 * i));
      if (sg && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      e.rdata = v;
      e.lat = 2; e.rd = 1; e.wr = 0;
    end else begin
      for (int i = 0; i < nb; i++) ref_mem[int'(addr[7:0]) + i] = wd[8 * i +: 8];
      base = int'(addr[7:0]) & 252;
      e.wdata = {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
      e.lat = (nb == 4) ? 2 : 3;
      e.rd  = (nb == 4) ? 0 : 1;
      e.wr  = 1;
    end
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin
      chk("req_ready_timeout", 32'(req_ready), 32'h1);
      return;
    end
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    e.hs = cyc;
    exp_q.push_back(e);
  endtask

  task automatic wait_resp(output logic [31:0] rd, output bit er);
    int n = 0;
    while (!resp_valid && n < 50) begin @(negedge clk); n++; end
    if (!resp_valid) chk("resp_timeout", 32'(resp_valid), 32'h1);
    rd = resp_rdata;
    er = resp_err;
    @(posedge clk); #1;
  endtask

  task automatic txn(input bit wr, input logic [1:0] sz, input bit sg,
                     input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output bit er);
    issue(wr, sz, sg, addr, wd);
    wait_resp(rd, er);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit          er;
    logic [7:0]  saved [0:3];
    int          n;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_mem_rw", 32'({mem_read, mem_write}), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Word store then load.
    txn(1'b1, 2'd2, 1'b0, 32'h04, 32'h0000_0088, rd, er);
    chk("st_word_wdata", last_wdata, 32'h0000_0088);
    txn(1'b0, 2'd2, 1'b0, 32'h04, 32'h0, rd, er);
    chk("ld_word", rd, 32'h0000_0088);
    chk("ld_word_err", 32'(er), 32'h0);

    // Byte read-modify-write.
    txn(1'b1, 2'd2, 1'b0, 32'h04, 32'h1122_3344, rd, er);
    txn(1'b1, 2'd0, 1'b0, 32'h06, 32'h0000_00CC, rd, er);
    chk("rmw_byte_wdata", last_wdata, 32'h11CC_3344);
    txn(1'b0, 2'd0, 1'b0, 32'h06, 32'h0, rd, er);
    chk("ld_byte_u", rd, 32'h0000_00CC);
    txn(1'b0, 2'd0, 1'b1, 32'h07, 32'h0, rd, er);
    chk("ld_byte_s_pos", rd, 32'h0000_0011);

    // Sign extension of halfwords and bytes.
    txn(1'b1, 2'd2, 1'b0, 32'h08, 32'h0000_F0FF, rd, er);
    txn(1'b0, 2'd1, 1'b1, 32'h08, 32'h0, rd, er);
    chk("ld_half_s", rd, 32'hFFFF_F0FF);
    txn(1'b0, 2'd1, 1'b0, 32'h08, 32'h0, rd, er);
    chk("ld_half_u", rd, 32'h0000_F0FF);
    txn(1'b1, 2'd1, 1'b0, 32'h0A, 32'h1234_BEEF, rd, er);
    chk("rmw_half_wdata", last_wdata, 32'hBEEF_F0FF);
    txn(1'b0, 2'd1, 1'b1, 32'h0A, 32'h0, rd, er);
    chk("ld_half_s_hi", rd, 32'hFFFF_BEEF);
    txn(1'b0, 2'd0, 1'b1, 32'h09, 32'h0, rd, er);
    chk("ld_byte_s_neg", rd, 32'hFFFF_FFF0);
    txn(1'b0, 2'd0, 1'b0, 32'h0B, 32'h0, rd, er);
    chk("ld_byte_u_b3", rd, 32'h0000_00BE);
    txn(1'b0, 2'd2, 1'b1, 32'h08, 32'h0, rd, er);
    chk("ld_word_signed_ignored", rd, 32'hBEEF_F0FF);

    // Error cases never touch memory.
    txn(1'b0, 2'd2, 1'b0, 32'h05, 32'h0, rd, er);
    chk("err_word_misalign", 32'(er), 32'h1);
    txn(1'b1, 2'd1, 1'b0, 32'h03, 32'hFFFF, rd, er);
    chk("err_half_misalign", 32'(er), 32'h1);
    txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, rd, er);
    chk("err_range", 32'(er), 32'h1);
    chk("err_range_rdata", rd, 32'h0);
    txn(1'b0, 2'd3, 1'b0, 32'h00, 32'h0, rd, er);
    chk("err_size3", 32'(er), 32'h1);
    txn(1'b1, 2'd0, 1'b0, 32'h200, 32'h55, rd, er);
    chk("err_byte_range", 32'(er), 32'h1);

    // Backpressure with a concurrent request that must be ignored.
    resp_ready = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 32'h04, 32'h0);
    n = 0;
    while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("bp_resp_valid", 32'(resp_valid), 32'h1);
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2;
      req_addr = 32'h0C; req_wdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      chk("bp_req_ready", 32'(req_ready), 32'h0);
      chk("bp_hold_valid", 32'(resp_valid), 32'h1);
      chk("bp_hold_rdata", resp_rdata, 32'h11CC_3344);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, rd, er);
    chk("bp_ignored_store", rd, 32'h0);

    // Reset during the read phase of a byte store.
    txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hA5A5_A5A5, rd, er);
    for (int i = 0; i < 4; i++) saved[i] = ref_mem[16 + i];
    issue(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_005A);
    chk("abort_in_rd", 32'(mem_read), 32'h1);
    rst = 1'b0;
    #1;
    chk("abort_req_ready", 32'(req_ready), 32'h1);
    chk("abort_mem_rw", 32'({mem_read, mem_write}), 32'h0);
    chk("abort_mem_addr", mem_addr, 32'h0);
    chk("abort_resp_valid", 32'(resp_valid), 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) ref_mem[16 + i] = saved[i];
    @(posedge clk); #1;
    chk("abort_mem_kept", dmem[4], 32'hA5A5_A5A5);
    txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er);
    chk("abort_reload", rd, 32'hA5A5_A5A5);

    repeat (3) @(posedge clk);
    #1;
    chk("drain_queue", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
